// File: rtl/switch_out_arbiter.sv
// switch_out_arbiter
//
// Per-egress-port packet arbiter. NUM_PORTS ingress streams compete for one
// egress port; whole packets (SOP..EOP) are granted round-robin and the granted
// stream is passed combinationally to egress with valid/ready flow control.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   in_valid   per-ingress beat valid
//   in_sop     per-ingress start-of-packet (qualified by in_valid)
//   in_eop     per-ingress end-of-packet (qualified by in_valid)
//   in_data    per-ingress payload, port i at [i*DATA_W +: DATA_W]
//   in_ready   per-ingress accept
//   out_valid  egress beat valid
//   out_sop    egress start-of-packet
//   out_eop    egress end-of-packet
//   out_data   egress payload
//   out_ready  egress accept
//   out_src    index of the granted ingress port
//   pkt_count  packets completed on egress (EOP beats accepted), wraps
//   proto_err  one-cycle pulse on a framing violation

module switch_out_arbiter #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          in_valid,
    input  logic [NUM_PORTS-1:0]          in_sop,
    input  logic [NUM_PORTS-1:0]          in_eop,
    input  logic [NUM_PORTS*DATA_W-1:0]   in_data,
    output logic [NUM_PORTS-1:0]          in_ready,
    output logic                          out_valid,
    output logic                          out_sop,
    output logic                          out_eop,
    output logic [DATA_W-1:0]             out_data,
    input  logic                          out_ready,
    output logic [$clog2(NUM_PORTS)-1:0]  out_src,
    output logic [CNT_W-1:0]              pkt_count,
    output logic                          proto_err
);

    localparam int unsigned SrcW = $clog2(NUM_PORTS);

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } state_e;

    state_e            state_q, state_d;
    logic [SrcW-1:0]   grant_q, grant_d;
    logic [SrcW-1:0]   last_grant_q, last_grant_d;
    logic              first_beat_q, first_beat_d;
    logic [CNT_W-1:0]  pkt_count_q, pkt_count_d;
    logic              proto_err_q, proto_err_d;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] stray;
    logic [DATA_W-1:0]    in_data_arr [NUM_PORTS];

    logic              rr_found;
    logic [SrcW-1:0]   rr_winner;
    logic [SrcW-1:0]   rr_sel;

    logic              beat_acc;

    // Unpack the flat payload bus so the mux can index by grant.
    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
        assign in_data_arr[i] = in_data[i*DATA_W +: DATA_W];
    end

    // Only SOP beats may open a packet; anything else seen while idle is a stray.
    assign req   = in_valid & in_sop;
    assign stray = in_valid & ~in_sop;

    // Round-robin search starting just after the last port served, so the
    // previous winner has the lowest priority.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_sel    = '0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            rr_sel = SrcW'((32'(last_grant_q) + k) % NUM_PORTS);
            if (!rr_found && req[rr_sel]) begin
                rr_found  = 1'b1;
                rr_winner = rr_sel;
            end
        end
    end

    // Egress mux and ingress ready.
    always_comb begin
        in_ready  = '0;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_data  = '0;
        unique case (state_q)
            StIdle: begin
                // Strays are consumed and discarded; SOP requesters wait for grant.
                in_ready = stray;
            end
            StXfer: begin
                out_valid         = in_valid[grant_q];
                out_sop           = in_sop[grant_q];
                out_eop           = in_eop[grant_q];
                out_data          = in_data_arr[grant_q];
                in_ready[grant_q] = out_ready;
            end
            default: begin
            end
        endcase
    end

    assign beat_acc = out_valid & out_ready;

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        first_beat_d = first_beat_q;
        pkt_count_d  = pkt_count_q;
        proto_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Any number of simultaneous strays collapse to one pulse.
                proto_err_d = |stray;
                if (rr_found) begin
                    state_d      = StXfer;
                    grant_d      = rr_winner;
                    first_beat_d = 1'b1;
                end
            end
            StXfer: begin
                if (beat_acc) begin
                    first_beat_d = 1'b0;
                    // A second SOP inside a packet is forwarded but flagged.
                    if (out_sop && !first_beat_q) begin
                        proto_err_d = 1'b1;
                    end
                    if (out_eop) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                        pkt_count_d  = pkt_count_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            // Start with the highest port as "last served" so port 0 wins first.
            last_grant_q <= SrcW'(NUM_PORTS - 1);
            first_beat_q <= 1'b0;
            pkt_count_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            first_beat_q <= first_beat_d;
            pkt_count_q  <= pkt_count_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign out_src   = grant_q;
    assign pkt_count = pkt_count_q;
    assign proto_err = proto_err_q;

endmodule
